spi_master_ctrl: RTL

SPI master sequencer (mode 0: CPOL=0, CPHA=0) for the SPI controller. It generates `sclk`, `cs_n` and `mosi` from a parallel transmit byte, and drives the downstream `ShiftRegSIPOIzq` receive register through `shift_ena` / `shift_din`. It latches that register's parallel output as the received byte when the transfer completes. One byte per transaction, MSB first.

---
 rtl/spi_master_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master sequencer, one DATA_W-bit transfer per start, MSB first.
// Feeds the downstream SIPO via shift_ena/shift_din and latches its output on completion.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    input  logic [DATA_W-1:0] rx_in,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              shift_ena,
    output logic              shift_din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bits;
    logic [DATA_W-1:0] r_sh;
    logic              w_phase_end;
    logic              w_trail_end;
    logic              w_last;

    assign w_phase_end = r_cnt == CW'(CLK_DIV - 1);
    // trail spans the final low half-period plus the cs_n hold, minus the DONE cycle
    assign w_trail_end = r_cnt == CW'(2 * CLK_DIV - 2);
    assign w_last      = r_bits == BW'(DATA_W - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_sh      <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            shift_ena <= 1'b0;
            shift_din <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
        end else begin
            shift_ena <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_sh    <= tx_data;
                    mosi    <= tx_data[DATA_W-1];
                    cs_n    <= 1'b0;
                    busy    <= 1'b1;
                    r_cnt   <= '0;
                    r_bits  <= '0;
                    r_state <= S_LEAD;
                end
                S_LEAD, S_LOW: if (w_phase_end) begin
                    r_cnt     <= '0;
                    sclk      <= 1'b1;
                    shift_din <= miso;
                    shift_ena <= 1'b1;
                    r_state   <= S_HIGH;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_HIGH: if (w_phase_end) begin
                    r_cnt   <= '0;
                    sclk    <= 1'b0;
                    r_bits  <= r_bits + BW'(1);
                    r_state <= w_last ? S_TRAIL : S_LOW;
                    if (!w_last) begin
                        r_sh <= r_sh << 1;
                        mosi <= r_sh[DATA_W-2];
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_TRAIL: if (w_trail_end) begin
                    r_cnt   <= '0;
                    r_state <= S_DONE;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    cs_n    <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    rx_data <= rx_in;
                    mosi    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
